// File: rtl/fibo_seq_if.sv
// Handshake and result bundle between a host and the Fibonacci/Lucas generator.
// The host drives the request fields; the generator drives the result fields.
interface fibo_seq_if #(
  parameter int W  = 16,
  parameter int NW = 8
);
  logic          start;
  logic [NW-1:0] n;
  logic          lucas;
  logic [W-1:0]  fibo;
  logic          finished;
  logic          busy;
  logic          overflow;

  modport master (output start, n, lucas, input fibo, finished, busy, overflow);
  modport slave  (input start, n, lucas, output fibo, finished, busy, overflow);
endinterface

// File: rtl/fibo_seq.sv
// Iterative Fibonacci/Lucas term generator: one term per clock, result after n+1 cycles.
// start is only sampled in IDLE/DONE; a held start never retriggers a second run.
module fibo_seq #(
  parameter int W  = 16,
  parameter int NW = 8
) (
  input  logic      clk,
  input  logic      reset,
  fibo_seq_if.slave io
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a, b;
  logic          oa, ob;
  logic [NW-1:0] cnt;
  logic [W:0]    sum;
  logic          accept, step, done;

  assign sum = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (io.start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          done      = 1'b1;
          state_nxt = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        if (!io.start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // oa/ob track whether the true value held in a/b has exceeded W bits;
  // only oa is reported, so a wrap confined to the look-ahead b stays hidden.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a           <= '0;
      b           <= '0;
      oa          <= 1'b0;
      ob          <= 1'b0;
      cnt         <= '0;
      io.fibo     <= '0;
      io.finished <= 1'b0;
      io.overflow <= 1'b0;
      io.busy     <= 1'b0;
    end else begin
      if (accept) begin
        a           <= io.lucas ? W'(2) : W'(0);
        b           <= W'(1);
        oa          <= 1'b0;
        ob          <= 1'b0;
        cnt         <= io.n;
        io.finished <= 1'b0;
      end
      if (step) begin
        a   <= b;
        b   <= sum[W-1:0];
        oa  <= ob;
        ob  <= oa | ob | sum[W];
        cnt <= cnt - NW'(1);
      end
      if (done) begin
        io.fibo     <= a;
        io.overflow <= oa;
        io.finished <= 1'b1;
      end
      io.busy <= (state_nxt == CALC);
    end
  end

endmodule

// File: tb/tb_fibo_seq.sv
// Directed bench for fibo_seq at W=8 and W=16; expected results are queued per run
// and checked by a monitor on each rising edge of finished.
module tb_fibo_seq;

  typedef struct packed {
    logic [15:0] f;
    logic        o;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   sel = 1'b0;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  logic pf8 = 1'b0;
  logic pf16 = 1'b0;

  logic [15:0] obs_fibo;
  logic        obs_fin, obs_busy, obs_ovf;

  fibo_seq_if #(.W(8),  .NW(8)) if8  ();
  fibo_seq_if #(.W(16), .NW(8)) if16 ();

  fibo_seq #(.W(8),  .NW(8)) u8  (.clk(clk), .reset(rst_n), .io(if8));
  fibo_seq #(.W(16), .NW(8)) u16 (.clk(clk), .reset(rst_n), .io(if16));

  always #5 clk = ~clk;

  always_comb begin
    obs_fibo = sel ? if16.fibo     : {8'h00, if8.fibo};
    obs_fin  = sel ? if16.finished : if8.finished;
    obs_busy = sel ? if16.busy     : if8.busy;
    obs_ovf  = sel ? if16.overflow : if8.overflow;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if8.finished && !pf8) begin
      if (q8.size() == 0) begin
        check("w8_unexpected_finish", 1, 0);
      end else begin
        e8 = q8.pop_front();
        check("w8_fibo", {16'h0, 8'h0, if8.fibo}, {16'h0, e8.f});
        check("w8_overflow", {31'h0, if8.overflow}, {31'h0, e8.o});
      end
    end
    if (if16.finished && !pf16) begin
      if (q16.size() == 0) begin
        check("w16_unexpected_finish", 1, 0);
      end else begin
        e16 = q16.pop_front();
        check("w16_fibo", {16'h0, if16.fibo}, {16'h0, e16.f});
        check("w16_overflow", {31'h0, if16.overflow}, {31'h0, e16.o});
      end
    end
    pf8  <= if8.finished;
    pf16 <= if16.finished;
  end

  task automatic set_in(input bit s, input logic st, input int nn, input bit luc);
    if (s) begin
      if16.start = st; if16.n = nn[7:0]; if16.lucas = luc;
    end else begin
      if8.start = st; if8.n = nn[7:0]; if8.lucas = luc;
    end
  endtask

  task automatic set_start(input bit s, input logic st);
    if (s) if16.start = st;
    else   if8.start  = st;
  endtask

  // Independent reference: wrapped value plus an exact value capped just above 2^w-1.
  function automatic exp_t model(input int nn, input bit luc, input int w);
    exp_t   r;
    longint mask, ma, mb, ea, eb, t;
    mask = (longint'(1) << w) - 1;
    ma = luc ? 2 : 0; mb = 1; ea = ma; eb = 1;
    for (int i = 0; i < nn; i++) begin
      t = (ma + mb) & mask; ma = mb; mb = t;
      t = ea + eb; ea = eb; eb = (t > mask) ? mask + 1 : t;
    end
    r.f = ma[15:0];
    r.o = (ea > mask);
    return r;
  endfunction

  task automatic run(input bit s, input int nn, input bit luc,
                     input logic [15:0] ef, input bit eo, input bit keep);
    exp_t e;
    int   cyc, bc;
    e.f = ef; e.o = eo;
    if (s) q16.push_back(e); else q8.push_back(e);
    @(negedge clk); sel = s; set_start(s, 1'b0);
    @(negedge clk); set_in(s, 1'b1, nn, luc);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!obs_busy && cyc < 8);
    check("accept_busy", {31'h0, obs_busy}, 1);
    check("accept_finished_clear", {31'h0, obs_fin}, 0);
    if (!keep) begin
      @(negedge clk); set_start(s, 1'b0);
    end
    bc = 1; cyc = 0;
    while (!obs_fin && cyc <= nn + 4) begin
      @(posedge clk); #1; cyc++;
      if (obs_busy) bc++;
    end
    check("latency", cyc, nn + 1);
    check("busy_cycles", bc, nn + 1);
    check("busy_low_at_done", {31'h0, obs_busy}, 0);
  endtask

  initial begin
    exp_t m;
    int   cyc;
    set_in(0, 1'b0, 0, 1'b0);
    set_in(1, 1'b0, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("reset_w8_outputs", {if8.fibo, if8.finished, if8.busy, if8.overflow}, 0);
    check("reset_w16_outputs", {if16.fibo, if16.finished, if16.busy, if16.overflow}, 0);
    rst_n = 1'b1;

    // start held for 5 cycles after accept, then dropped mid-run
    fork
      run(0, 6, 1'b0, 16'd8, 1'b0, 1'b1);
      begin repeat (7) @(negedge clk); if8.start = 1'b0; end
    join

    run(1, 0, 1'b0, 16'd0, 1'b0, 1'b0);
    run(1, 0, 1'b1, 16'd2, 1'b0, 1'b0);

    fork
      run(1, 5, 1'b1, 16'd11, 1'b0, 1'b0);
      begin repeat (4) @(negedge clk); if16.n = 8'd9; end
    join

    run(0, 13, 1'b0, 16'd233, 1'b0, 1'b0);
    run(0, 14, 1'b0, 16'd121, 1'b1, 1'b0);
    run(0, 10, 1'b1, 16'd123, 1'b0, 1'b0);
    run(1, 24, 1'b0, 16'd46368, 1'b0, 1'b0);
    run(1, 25, 1'b0, 16'd9489, 1'b1, 1'b0);

    // held start through completion must not retrigger
    run(1, 7, 1'b0, 16'd13, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_no_retrigger_busy", {31'h0, if16.busy}, 0);
      check("hold_finished_stays", {31'h0, if16.finished}, 1);
    end
    run(1, 3, 1'b0, 16'd2, 1'b0, 1'b0);

    m = model(255, 1'b0, 8);
    run(0, 255, 1'b0, m.f, m.o, 1'b0);
    m = model(255, 1'b1, 16);
    run(1, 255, 1'b1, m.f, m.o, 1'b0);

    // reset asserted mid-run aborts without presenting a result
    @(negedge clk); sel = 1'b1; if16.start = 1'b0;
    @(negedge clk); set_in(1, 1'b1, 20, 1'b0);
    @(posedge clk); #1;
    check("abort_run_busy", {31'h0, if16.busy}, 1);
    @(negedge clk); if16.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check("abort_fibo", {16'h0, if16.fibo}, 0);
    check("abort_flags", {29'h0, if16.finished, if16.busy, if16.overflow}, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    run(1, 20, 1'b0, 16'd6765, 1'b0, 1'b0);

    cyc = 0;
    while ((q8.size() != 0 || q16.size() != 0) && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    check("w8_queue_drained", q8.size(), 0);
    check("w16_queue_drained", q16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
